// File: rtl/gpu_mem_pkg.sv
// Shared definitions for the GPU host-side RAM port: FSM encoding, default
// read latency and the value returned for out-of-range reads.
package gpu_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_e;

    localparam int         DEFAULT_READ_LATENCY = 2;
    localparam logic [7:0] OOR_READ_DATA        = 8'hFF;

endpackage

// File: rtl/gpu_rr_arb2.sv
// Two-way round-robin arbiter. The pointer remembers the last winner so that
// on a tie the other requester is picked; it only moves when a grant is taken.
module gpu_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       take_i,
    output logic       valid_o,
    output logic       winner_o
);

    logic lastGrant_q;
    logic lastGrant_d;

    // After reset the pointer reads "last granted 1", so requester 0 wins the first tie.
    always_comb begin
        valid_o     = |req_i;
        winner_o    = (req_i == 2'b11) ? ~lastGrant_q : req_i[1];
        lastGrant_d = (take_i && valid_o) ? winner_o : lastGrant_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lastGrant_q <= 1'b1;
        end else begin
            lastGrant_q <= lastGrant_d;
        end
    end

endmodule

// File: rtl/gpu_host_ram_arbiter.sv
// Shares RAM port B between the Z80 bus interface (requester 0) and the RS232
// debugger (requester 1); one transaction at a time, all outputs registered.
module gpu_host_ram_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int ADDR_SIZE    = 14,
    parameter int NUM_WORDS    = 2**ADDR_SIZE,
    parameter int READ_LATENCY = DEFAULT_READ_LATENCY
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_0,
    input  logic                 req_1,
    input  logic                 wr_0,
    input  logic                 wr_1,
    input  logic [19:0]          addr_0,
    input  logic [19:0]          addr_1,
    input  logic [7:0]           wdata_0,
    input  logic [7:0]           wdata_1,
    output logic                 ack_0,
    output logic                 ack_1,
    output logic [7:0]           rdata_0,
    output logic [7:0]           rdata_1,
    output logic                 range_err,
    output logic                 busy,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic                 ram_wr_en,
    output logic [7:0]           ram_wdata,
    input  logic [7:0]           ram_rdata
);

    localparam int          CNT_W     = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [20:0] WORDS_EXT = 21'(NUM_WORDS);

    state_e               state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 wr_q, wr_d;
    logic                 oor_q, oor_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ack0_q, ack0_d;
    logic                 ack1_q, ack1_d;
    logic                 rangeErr_q, rangeErr_d;
    logic                 busy_q, busy_d;
    logic [ADDR_SIZE-1:0] ramAddr_q, ramAddr_d;
    logic                 ramWrEn_q, ramWrEn_d;
    logic [7:0]           ramWdata_q, ramWdata_d;
    logic [7:0]           rdata0_q, rdata0_d;
    logic [7:0]           rdata1_q, rdata1_d;

    logic                 reqValid;
    logic                 winner;
    logic                 take;
    logic                 selWr;
    logic [19:0]          selAddr;
    logic [7:0]           selWdata;
    logic                 selOor;
    logic [7:0]           readValue;

    gpu_rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .req_i    ({req_1, req_0}),
        .take_i   (take),
        .valid_o  (reqValid),
        .winner_o (winner)
    );

    // The range check uses the full 20-bit address so aliases of valid words are rejected.
    always_comb begin
        selWr     = winner ? wr_1 : wr_0;
        selAddr   = winner ? addr_1 : addr_0;
        selWdata  = winner ? wdata_1 : wdata_0;
        selOor    = ({1'b0, selAddr} >= WORDS_EXT);
        readValue = oor_q ? OOR_READ_DATA : ram_rdata;
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        wr_d       = wr_q;
        oor_d      = oor_q;
        cnt_d      = cnt_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        rangeErr_d = 1'b0;
        ramAddr_d  = ramAddr_q;
        ramWrEn_d  = 1'b0;
        ramWdata_d = ramWdata_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        take       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (reqValid) begin
                    take       = 1'b1;
                    owner_d    = winner;
                    wr_d       = selWr;
                    oor_d      = selOor;
                    ramAddr_d  = selAddr[ADDR_SIZE-1:0];
                    ramWdata_d = selWdata;
                    ramWrEn_d  = selWr && !selOor;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (wr_q) begin
                    state_d    = ST_ACK;
                    ack0_d     = !owner_q;
                    ack1_d     = owner_q;
                    rangeErr_d = oor_q;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(READ_LATENCY - 1);
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = ST_ACK;
                    ack0_d     = !owner_q;
                    ack1_d     = owner_q;
                    rangeErr_d = oor_q;
                    if (owner_q) begin
                        rdata1_d = readValue;
                    end else begin
                        rdata0_d = readValue;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            wr_q       <= 1'b0;
            oor_q      <= 1'b0;
            cnt_q      <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rangeErr_q <= 1'b0;
            busy_q     <= 1'b0;
            ramAddr_q  <= '0;
            ramWrEn_q  <= 1'b0;
            ramWdata_q <= 8'h00;
            rdata0_q   <= 8'h00;
            rdata1_q   <= 8'h00;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            wr_q       <= wr_d;
            oor_q      <= oor_d;
            cnt_q      <= cnt_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rangeErr_q <= rangeErr_d;
            busy_q     <= busy_d;
            ramAddr_q  <= ramAddr_d;
            ramWrEn_q  <= ramWrEn_d;
            ramWdata_q <= ramWdata_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign ack_0     = ack0_q;
    assign ack_1     = ack1_q;
    assign range_err = rangeErr_q;
    assign busy      = busy_q;
    assign ram_addr  = ramAddr_q;
    assign ram_wr_en = ramWrEn_q;
    assign ram_wdata = ramWdata_q;
    assign rdata_0   = rdata0_q;
    assign rdata_1   = rdata1_q;

endmodule

// File: doc/gpu_host_ram_arbiter.md
GPU_HOST_RAM_ARBITER -- requirements
Module: gpu_host_ram_arbiter

Interface
REQ-001 Parameter ADDR_SIZE, default 14: RAM address width driven on ram_addr.
REQ-002 Parameter NUM_WORDS, default 2**ADDR_SIZE: highest legal address + 1.
REQ-003 Parameter READ_LATENCY, default 2: clocks from RAM address sample to valid RAM data.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock; RAM host port is clocked from the same net.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 req_0 / req_1  in  1  requester 0 (Z80 bus interface) / requester 1 (RS232 debugger) transaction request.
REQ-008 wr_0 / wr_1  in  1  1 = write, 0 = read.
REQ-009 addr_0 / addr_1  in  20  byte address.
REQ-010 wdata_0 / wdata_1  in  8  write data.
REQ-011 ack_0 / ack_1  out  1  one-cycle completion pulse.
REQ-012 rdata_0 / rdata_1  out  8  read data, valid from the ack cycle until that requester's next read ack.
REQ-013 range_err  out  1  one-cycle pulse with ack when the completed address was >= NUM_WORDS.
REQ-014 busy  out  1  high in every non-IDLE state.
REQ-015 ram_addr  out  ADDR_SIZE  to RAM port B address.
REQ-016 ram_wr_en  out  1  to RAM port B write enable.
REQ-017 ram_wdata  out  8  to RAM port B write data.
REQ-018 ram_rdata  in  8  from RAM port B registered output.

Function
REQ-019 Requester holds req and its command stable until it samples ack, then drops or re-presents req on the following cycle.
REQ-020 FSM states: IDLE, ISSUE, WAIT, ACK; all outputs are registered.
REQ-021 IDLE: on any req, the winner is latched, its addr/wr/wdata are loaded into ram_addr/ram_wr_en/ram_wdata, and the FSM enters ISSUE on the next cycle.
REQ-022 Arbitration: a single requester wins; if both request, the one not granted last wins (round-robin pointer updates on each grant).
REQ-023 ISSUE lasts exactly 1 cycle; ram_wr_en is high only in ISSUE and only for an in-range write.
REQ-024 Write: ISSUE goes to ACK; with req seen in cycle 0, ack is asserted in cycle 2.
REQ-025 Read: ISSUE goes to WAIT for READ_LATENCY cycles; ram_rdata is captured into rdata_n at the end of the last WAIT cycle; ack is asserted in cycle 2+READ_LATENCY (cycle 4 at default).
REQ-026 ACK lasts 1 cycle, pulses only the granted ack_n, and returns to IDLE; a new grant can occur in the next cycle, giving a write throughput of one per 3 cycles.
REQ-027 Address compare uses all 20 bits. For addr >= NUM_WORDS, the write is suppressed (ram_wr_en stays 0), a read returns 8'hFF, the timing is unchanged, and range_err pulses with ack.
REQ-028 ram_addr carries addr[ADDR_SIZE-1:0] and is held from ISSUE through ACK.
REQ-029 req changes while not in IDLE are ignored; the pending request is arbitrated on return to IDLE.
REQ-030 rdata of the non-granted requester never changes.

Reset
REQ-031 Reset state: state = IDLE, ack_0/ack_1/range_err/busy/ram_wr_en = 0, ram_addr = 0, ram_wdata = 0, rdata_0/rdata_1 = 0, round-robin pointer = "last granted 1" (requester 0 wins the first tie).
REQ-032 Reset mid-transaction abandons it with no ack; a write whose ISSUE cycle already completed remains in RAM.

Structure
REQ-033 Shared package gpu_mem_pkg holds the FSM state encoding, the default READ_LATENCY, and the 8'hFF out-of-range read value.
REQ-034 One sub-module, gpu_rr_arb2 (2-way round-robin grant with pointer), is instantiated once; everything else is flat.

Verification
REQ-035 Single write: req_0=1, wr_0=1, addr_0=20'h00010, wdata_0=8'hA5 at cycle 0 -> ram_wr_en=1 with ram_addr=14'h0010 in cycle 1 only; ack_0 in cycle 2.
REQ-036 Read-back: req_1 read of addr 20'h00010 -> ack_1 in cycle 4 with rdata_1=8'hA5; rdata_0 unchanged.
REQ-037 Contention: req_0 and req_1 both rise in the same cycle after reset -> requester 0 is served first, then requester 1; if both are held continuously, grants alternate 0,1,0,1.
REQ-038 Out of range: write 20'h04000 with data 8'h5A -> ram_wr_en stays 0 and range_err pulses with ack; a read of 20'h04000 returns 8'hFF.
REQ-039 Reset in WAIT: read issued, reset asserted in cycle 2 -> no ack, busy=0 the cycle after reset, and the next request is served normally.
